// File: rtl/change_dispenser_if.sv
// Payout request, restock and ejector/status signals of the change dispenser.
// The master side is the controller or testbench; the slave side is the dispenser.
interface change_dispenser_if;
    localparam int unsigned AMT_W = 5;
    localparam int unsigned CNT_W = 8;

    logic             req_valid;
    logic [AMT_W-1:0] req_amount;
    logic             req_ready;
    logic             load_nickel;
    logic             load_dime;
    logic             nickel_eject;
    logic             dime_eject;
    logic             busy;
    logic             done;
    logic [AMT_W-1:0] short_units;
    logic [CNT_W-1:0] nickel_count;
    logic [CNT_W-1:0] dime_count;

    modport master (
        output req_valid, req_amount, load_nickel, load_dime,
        input  req_ready, nickel_eject, dime_eject, busy, done,
               short_units, nickel_count, dime_count
    );

    modport slave (
        input  req_valid, req_amount, load_nickel, load_dime,
        output req_ready, nickel_eject, dime_eject, busy, done,
               short_units, nickel_count, dime_count
    );
endinterface

// File: rtl/change_dispenser.sv
// Coin change dispenser: pays a nickel-unit amount using dimes first, then nickels,
// pulsing one solenoid at a time and tracking saturating coin inventories.
module change_dispenser #(
    parameter int unsigned PULSE_CYCLES = 4,
    parameter int unsigned GAP_CYCLES   = 2,
    parameter logic [7:0]  NICKEL_INIT  = 8'd20,
    parameter logic [7:0]  DIME_INIT    = 8'd20
) (
    input  logic                clock,
    input  logic                reset,
    change_dispenser_if.slave   bus
);
    localparam int unsigned AMT_W = 5;
    localparam int unsigned CNT_W = 8;
    localparam int unsigned TMR_W = 4;

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] SELECT = 3'd1;
    localparam logic [2:0] PULSE  = 3'd2;
    localparam logic [2:0] GAP    = 3'd3;
    localparam logic [2:0] FINISH = 3'd4;

    localparam logic [TMR_W-1:0] PULSE_LAST = TMR_W'(PULSE_CYCLES - 1);
    localparam logic [TMR_W-1:0] GAP_LAST   = TMR_W'(GAP_CYCLES - 1);

    logic [2:0]       state, state_nxt;
    logic [AMT_W-1:0] remaining, remaining_nxt;
    logic [AMT_W-1:0] short_q, short_nxt;
    logic [TMR_W-1:0] tmr, tmr_nxt;
    logic             is_dime, is_dime_nxt;
    logic [CNT_W-1:0] nickel_q, nickel_nxt;
    logic [CNT_W-1:0] dime_q, dime_nxt;
    logic             nickel_dec, dime_dec;
    logic             nickel_eject_q, dime_eject_q, busy_q, done_q, ready_q;

    // Next-state, payout bookkeeping and inventory update
    always_comb begin
        state_nxt     = state;
        remaining_nxt = remaining;
        short_nxt     = short_q;
        tmr_nxt       = tmr;
        is_dime_nxt   = is_dime;
        nickel_dec    = 1'b0;
        dime_dec      = 1'b0;

        case (state)
            IDLE: begin
                if (bus.req_valid) begin
                    remaining_nxt = bus.req_amount;
                    short_nxt     = '0;
                    state_nxt     = SELECT;
                end
            end
            SELECT: begin
                tmr_nxt = '0;
                // Dimes only when they cannot overpay; never substitute a dime for one nickel
                if (remaining >= AMT_W'(2) && dime_q != '0) begin
                    dime_dec      = 1'b1;
                    is_dime_nxt   = 1'b1;
                    remaining_nxt = AMT_W'(remaining - AMT_W'(2));
                    state_nxt     = PULSE;
                end else if (remaining >= AMT_W'(1) && nickel_q != '0) begin
                    nickel_dec    = 1'b1;
                    is_dime_nxt   = 1'b0;
                    remaining_nxt = AMT_W'(remaining - AMT_W'(1));
                    state_nxt     = PULSE;
                end else begin
                    short_nxt = remaining;
                    state_nxt = FINISH;
                end
            end
            PULSE: begin
                if (tmr == PULSE_LAST) begin
                    tmr_nxt   = '0;
                    state_nxt = GAP;
                end else begin
                    tmr_nxt = TMR_W'(tmr + TMR_W'(1));
                end
            end
            GAP: begin
                if (tmr == GAP_LAST) begin
                    tmr_nxt   = '0;
                    state_nxt = SELECT;
                end else begin
                    tmr_nxt = TMR_W'(tmr + TMR_W'(1));
                end
            end
            FINISH:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase

        // Restock and payout in the same cycle cancel out
        case ({bus.load_nickel, nickel_dec})
            2'b10:   nickel_nxt = (nickel_q == '1) ? nickel_q : CNT_W'(nickel_q + CNT_W'(1));
            2'b01:   nickel_nxt = CNT_W'(nickel_q - CNT_W'(1));
            default: nickel_nxt = nickel_q;
        endcase

        case ({bus.load_dime, dime_dec})
            2'b10:   dime_nxt = (dime_q == '1) ? dime_q : CNT_W'(dime_q + CNT_W'(1));
            2'b01:   dime_nxt = CNT_W'(dime_q - CNT_W'(1));
            default: dime_nxt = dime_q;
        endcase
    end

    // State and registered outputs; status flags are decoded from the next state
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            remaining      <= '0;
            short_q        <= '0;
            tmr            <= '0;
            is_dime        <= 1'b0;
            nickel_q       <= NICKEL_INIT;
            dime_q         <= DIME_INIT;
            nickel_eject_q <= 1'b0;
            dime_eject_q   <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            ready_q        <= 1'b1;
        end else begin
            state          <= state_nxt;
            remaining      <= remaining_nxt;
            short_q        <= short_nxt;
            tmr            <= tmr_nxt;
            is_dime        <= is_dime_nxt;
            nickel_q       <= nickel_nxt;
            dime_q         <= dime_nxt;
            nickel_eject_q <= (state_nxt == PULSE) && !is_dime_nxt;
            dime_eject_q   <= (state_nxt == PULSE) && is_dime_nxt;
            busy_q         <= (state_nxt != IDLE);
            done_q         <= (state_nxt == FINISH);
            ready_q        <= (state_nxt == IDLE);
        end
    end

    assign bus.req_ready    = ready_q;
    assign bus.nickel_eject = nickel_eject_q;
    assign bus.dime_eject   = dime_eject_q;
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.short_units  = short_q;
    assign bus.nickel_count = nickel_q;
    assign bus.dime_count   = dime_q;
endmodule

// File: tb/tb_change_dispenser.sv
// Directed testbench for change_dispenser: payout sequences, shortfalls, restock
// collisions, saturation and asynchronous reset abort.
module tb_change_dispenser;
    logic clock = 1'b0;
    logic reset = 1'b1;

    change_dispenser_if bus ();

    change_dispenser dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;

    // Pulse monitor: counts pulses, flags wrong pulse lengths and overlaps
    int d_pulses = 0, n_pulses = 0, bad_runs = 0, overlap = 0;
    int d_run = 0, n_run = 0;

    always @(negedge clock) begin
        if (bus.dime_eject && bus.nickel_eject) overlap++;
        if (bus.dime_eject) begin
            if (d_run == 0) d_pulses++;
            d_run++;
        end else begin
            if (d_run != 0 && d_run != 4) bad_runs++;
            d_run = 0;
        end
        if (bus.nickel_eject) begin
            if (n_run == 0) n_pulses++;
            n_run++;
        end else begin
            if (n_run != 0 && n_run != 4) bad_runs++;
            n_run = 0;
        end
    end

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Issue one request and wait for done; optional mid-payout poke and select-cycle restock
    task automatic send(input logic [4:0] amt, input bit poke, input bit load_at_sel,
                        output int lat, output int dp, output int np);
        int d0, n0, nc_sel;
        d0 = d_pulses;
        n0 = n_pulses;
        nc_sel = 0;
        @(negedge clock);
        bus.req_valid  = 1'b1;
        bus.req_amount = amt;
        @(negedge clock);
        bus.req_valid = 1'b0;
        lat = 1;
        check("busy_after_accept", int'(bus.busy), 1);
        check("ready_after_accept", int'(bus.req_ready), 0);
        if (load_at_sel) begin
            nc_sel = int'(bus.nickel_count);
            bus.load_nickel = 1'b1;
        end
        while (!bus.done && lat < 400) begin
            @(negedge clock);
            lat++;
            bus.req_valid = 1'b0;
            if (lat == 2 && load_at_sel) begin
                bus.load_nickel = 1'b0;
                check("nickel_cnt_collide", int'(bus.nickel_count), nc_sel);
                check("nickel_eject_collide", int'(bus.nickel_eject), 1);
            end
            if (lat == 5 && poke) begin
                bus.req_valid  = 1'b1;
                bus.req_amount = 5'd31;
            end
        end
        if (lat >= 400) check("done_timeout", 0, 1);
        @(negedge clock);
        check("ready_after_done", int'(bus.req_ready), 1);
        dp = d_pulses - d0;
        np = n_pulses - n0;
    endtask

    task automatic load(input bit dime, input int n);
        @(negedge clock);
        if (dime) bus.load_dime = 1'b1;
        else bus.load_nickel = 1'b1;
        repeat (n) @(negedge clock);
        bus.load_dime   = 1'b0;
        bus.load_nickel = 1'b0;
    endtask

    initial begin
        int lat, dp, np;
        bus.req_valid   = 1'b0;
        bus.req_amount  = '0;
        bus.load_nickel = 1'b0;
        bus.load_dime   = 1'b0;

        repeat (2) @(negedge clock);
        check("rst_ready", int'(bus.req_ready), 1);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_done", int'(bus.done), 0);
        check("rst_ejects", int'({bus.dime_eject, bus.nickel_eject}), 0);
        check("rst_short", int'(bus.short_units), 0);
        check("rst_nickels", int'(bus.nickel_count), 20);
        check("rst_dimes", int'(bus.dime_count), 20);
        reset = 1'b0;

        // 25 cents: dime, dime, nickel; request poked mid-payout must be ignored
        send(5'd5, 1'b1, 1'b0, lat, dp, np);
        check("a5_latency", lat, 23);
        check("a5_dime_pulses", dp, 2);
        check("a5_nickel_pulses", np, 1);
        check("a5_short", int'(bus.short_units), 0);
        check("a5_dimes", int'(bus.dime_count), 18);
        check("a5_nickels", int'(bus.nickel_count), 19);

        send(5'd0, 1'b0, 1'b0, lat, dp, np);
        check("a0_latency", lat, 2);
        check("a0_pulses", dp + np, 0);
        check("a0_short", int'(bus.short_units), 0);

        // Drain inventory: 31 -> 15 dimes + 1 nickel
        send(5'd31, 1'b0, 1'b0, lat, dp, np);
        check("a31_dime_pulses", dp, 15);
        check("a31_nickel_pulses", np, 1);
        check("a31_short", int'(bus.short_units), 0);
        // 10 with 3 dimes left: 3 dimes then 4 nickels
        send(5'd10, 1'b0, 1'b0, lat, dp, np);
        check("a10_dime_pulses", dp, 3);
        check("a10_nickel_pulses", np, 4);
        check("a10_dimes", int'(bus.dime_count), 0);
        check("a10_nickels", int'(bus.nickel_count), 14);
        send(5'd12, 1'b0, 1'b0, lat, dp, np);
        check("a12_nickels", int'(bus.nickel_count), 2);

        // No dimes, two nickels, amount 3
        send(5'd3, 1'b0, 1'b0, lat, dp, np);
        check("s34_nickel_pulses", np, 2);
        check("s34_dime_pulses", dp, 0);
        check("s34_short", int'(bus.short_units), 1);
        check("s34_nickels", int'(bus.nickel_count), 0);
        repeat (3) @(negedge clock);
        check("short_hold", int'(bus.short_units), 1);

        // One dime, no nickels, amount 3
        load(1'b1, 1);
        check("load_dime_1", int'(bus.dime_count), 1);
        send(5'd3, 1'b0, 1'b0, lat, dp, np);
        check("s35_dime_pulses", dp, 1);
        check("s35_nickel_pulses", np, 0);
        check("s35_short", int'(bus.short_units), 1);
        check("s35_dimes", int'(bus.dime_count), 0);

        // No overpay: one unit owed, dimes present, no nickels
        load(1'b1, 2);
        send(5'd1, 1'b0, 1'b0, lat, dp, np);
        check("nooverpay_pulses", dp + np, 0);
        check("nooverpay_short", int'(bus.short_units), 1);
        check("nooverpay_dimes", int'(bus.dime_count), 2);

        // Restock colliding with the nickel selection
        load(1'b0, 1);
        send(5'd1, 1'b0, 1'b1, lat, dp, np);
        check("collide_nickel_pulses", np, 1);
        check("collide_nickels", int'(bus.nickel_count), 1);
        check("collide_short", int'(bus.short_units), 0);

        // Saturation at 255
        load(1'b0, 254);
        check("sat_reach", int'(bus.nickel_count), 255);
        load(1'b0, 1);
        check("sat_hold", int'(bus.nickel_count), 255);

        check("pulse_lengths", bad_runs, 0);
        check("no_overlap", overlap, 0);

        // Reset during the second pulse cycle of a dime
        @(negedge clock);
        bus.req_valid  = 1'b1;
        bus.req_amount = 5'd2;
        @(negedge clock);
        bus.req_valid = 1'b0;
        @(negedge clock);
        @(negedge clock);
        check("pre_rst_dime_eject", int'(bus.dime_eject), 1);
        #1 reset = 1'b1;
        #1;
        check("rst_mid_eject", int'(bus.dime_eject), 0);
        check("rst_mid_busy", int'(bus.busy), 0);
        check("rst_mid_dimes", int'(bus.dime_count), 20);
        check("rst_mid_nickels", int'(bus.nickel_count), 20);
        @(negedge clock);
        check("rst_mid_no_done", int'(bus.done), 0);
        reset = 1'b0;
        bus.req_valid  = 1'b1;
        bus.req_amount = 5'd0;
        @(negedge clock);
        bus.req_valid = 1'b0;
        check("post_rst_accept", int'(bus.busy), 1);
        @(negedge clock);
        check("post_rst_done", int'(bus.done), 1);
        check("post_rst_no_eject", int'({bus.dime_eject, bus.nickel_eject}), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
